// File: rtl/arbitro_memoria.sv
// Memory arbiter between the CPU multicycle datapath and the USART program loader.
// One access at a time through a 4-state FSM; boot mode gives the loader exclusive ownership.
module arbitro_memoria #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MAX_ESPERA = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_end,
  input  logic [DATA_W-1:0] cpu_dado,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_end,
  input  logic [DATA_W-1:0] ld_dado,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_end,
  output logic [DATA_W-1:0] mem_dado,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_saida,
  output logic              cpu_parado,
  output logic              dono,
  output logic [1:0]        estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2,
    ACK      = 2'd3
  } estado_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ESPERA);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] mem_end_q, mem_end_d;
  logic [DATA_W-1:0] mem_dado_q, mem_dado_d;
  logic              mem_we_q, mem_we_d;
  logic              dono_q, dono_d;
  logic [3:0]        espera_q, espera_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic cpu_eleg;
  logic ld_vence;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      mem_end_q   <= '0;
      mem_dado_q  <= '0;
      mem_we_q    <= 1'b0;
      dono_q      <= 1'b0;
      espera_q    <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      estado_q    <= estado_d;
      mem_end_q   <= mem_end_d;
      mem_dado_q  <= mem_dado_d;
      mem_we_q    <= mem_we_d;
      dono_q      <= dono_d;
      espera_q    <= espera_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // The loader wins when it is alone or once it has lost MAX_ESPERA contended rounds in a row.
  assign cpu_eleg = cpu_req & ~boot;
  assign ld_vence = ld_req & (~cpu_eleg | (espera_q == MAX_CNT));

  always_comb begin
    estado_d    = estado_q;
    mem_end_d   = mem_end_q;
    mem_dado_d  = mem_dado_q;
    mem_we_d    = mem_we_q;
    dono_d      = dono_q;
    espera_d    = espera_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    case (estado_q)
      OCIOSO: begin
        mem_we_d = 1'b0;
        if (!ld_req) begin
          espera_d = '0;
        end
        if (ld_vence) begin
          mem_end_d  = ld_end;
          mem_dado_d = ld_dado;
          mem_we_d   = ld_we;
          dono_d     = 1'b1;
          espera_d   = '0;
          estado_d   = ACESSO;
        end else if (cpu_eleg) begin
          mem_end_d  = cpu_end;
          mem_dado_d = cpu_dado;
          mem_we_d   = cpu_we;
          dono_d     = 1'b0;
          estado_d   = ACESSO;
          if (ld_req && (espera_q != MAX_CNT)) begin
            espera_d = espera_q + 4'd1;
          end
        end
      end
      // Dropping the write strobe here guarantees a single write per access.
      ACESSO: begin
        mem_we_d = 1'b0;
        estado_d = RESPOSTA;
      end
      RESPOSTA: begin
        if (dono_q) begin
          ld_rdata_d = mem_saida;
          ld_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = mem_saida;
          cpu_ack_d   = 1'b1;
        end
        estado_d = ACK;
      end
      ACK: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign cpu_ack    = cpu_ack_q;
  assign ld_ack     = ld_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ld_rdata   = ld_rdata_q;
  assign mem_end    = mem_end_q;
  assign mem_dado   = mem_dado_q;
  assign mem_we     = mem_we_q;
  assign dono       = dono_q;
  assign estado     = estado_q;
  assign cpu_parado = boot | (cpu_req & ~cpu_ack_q);

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Arbitrates the single synchronous program/data memory between the processor's multicycle datapath (CPU port) and the USART program loader (loader port).
- Sits between the two requesters and the `memoria` instance. It drives the memory's address, data and write lines and returns read data through a req/ack handshake.
- Provides a boot mode in which the loader owns the memory exclusively, plus a starvation bound for the loader during normal execution.

Parameters:
- ADDR_W, 10, memory address width (matches the memory's endereco input).
- DATA_W, 32, data word width.
- MAX_ESPERA, 4, number of consecutive contended arbitrations the loader may lose before it is forced to win (range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- boot  input  1  1 = loader-exclusive mode; CPU requests ignored.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req.
- cpu_end  input  ADDR_W  CPU address.
- cpu_dado  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1 and held until the next CPU access completes.
- ld_req, ld_we, ld_end, ld_dado  inputs  1/1/ADDR_W/DATA_W  loader equivalents.
- ld_ack  output  1  loader completion pulse.
- ld_rdata  output  DATA_W  loader read data (same rules as cpu_rdata).
- mem_end  output  ADDR_W  to the memory's address input.
- mem_dado  output  DATA_W  to the memory's data input.
- mem_we  output  1  to the memory's write input.
- mem_saida  input  DATA_W  memory read data (1-cycle synchronous read).
- cpu_parado  output  1  = boot OR (cpu_req AND NOT cpu_ack); stall indication to the control unit.
- dono  output  1  0 = CPU, 1 = loader; owner of the current/last access.
- estado  output  2  FSM state code, for debug LEDs.

Behaviour:
- Reset (async, rst=1): state OCIOSO; all outputs 0; mem_we=0; wait counter=0; dono=0. An access in flight is abandoned and no ack is issued.
- FSM states and codes: OCIOSO=0, ACESSO=1, RESPOSTA=2, ACK=3.
- OCIOSO: arbitrate on sampled requests, where CPU eligibility = cpu_req AND NOT boot.
  - Only one eligible request: grant it.
  - Both eligible: CPU wins unless wait counter = MAX_ESPERA; in that case the loader wins.
  - On grant, register mem_end/mem_dado/mem_we from the winner and set dono; go to ACESSO.
  - No request: stay in OCIOSO with mem_we=0.
- Wait counter:
  - +1 when both are eligible and the CPU wins.
  - Cleared when the loader is granted, or when ld_req=0 in OCIOSO.
  - Saturates at MAX_ESPERA.
- ACESSO: memory signals stable; the memory acts at the end-of-cycle edge; go to RESPOSTA. mem_we is cleared on leaving ACESSO, so each write happens exactly once.
- RESPOSTA: mem_saida is valid. At the edge, capture it into the owner's rdata (writes also capture it, value don't-care), assert the owner's ack, and go to ACK.
- ACK: the owner's ack is high for exactly this cycle. The requester must drop req at the edge that ends the ack cycle. Then go to OCIOSO.
- Latency: request visible in cycle n gives ack high in cycle n+3. Back-to-back accesses occur every 4 cycles.
- The non-owner's ack and rdata are never disturbed.
- boot changing mid-access: the current access completes normally. The new value applies at the next OCIOSO arbitration.
- A requester dropping req before ack: the access still completes and ack still pulses. Requester error; no recovery action.
- cpu_ack and ld_ack are never high in the same cycle.
- Address is not range-checked; the width equals the memory depth.

Test Plan:
- Idle, boot=0, single CPU read at address 0x005 (memory holds 0x12345678) → mem_we stays 0; cpu_ack high exactly cycle n+3; cpu_rdata=0x12345678; estado sequence 0,1,2,3,0.
- boot=1: loader writes 0xDEADBEEF to 0x3FF while cpu_req=1 → loader granted, CPU never acked, cpu_parado=1. Then boot=0 and CPU reads 0x3FF → 0xDEADBEEF.
- boot=0, cpu_req and ld_req held continuously (requesters re-request immediately after ack), MAX_ESPERA=4 → grant order CPU,CPU,CPU,CPU,LD,CPU,CPU,CPU,CPU,LD; dono tracks each grant.
- CPU write 0x0000AAAA to 0x010, then loader read of 0x010 → ld_rdata=0x0000AAAA; cpu_rdata unchanged by the loader access; exactly one mem_we cycle for the write.
- rst asserted asynchronously during RESPOSTA of a CPU read → outputs zero immediately, no cpu_ack. After release with cpu_req still high → a fresh access completes 3 cycles later.
- boot rises during ACESSO of a CPU write → the write completes (cpu_ack pulses, memory updated); the next pending CPU request is not granted while boot=1.
